// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
// Holds the funct3 operation codes, the FSM state encoding and the fixed latency.
package muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam int unsigned MULDIV_LATENCY = 34;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on operand
// magnitudes, sharing one add/sub datapath, with sign and special-case fix-up at the end.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] y
);

   logic [1:0]        state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   m_q, m_d;
   logic [XLEN-1:0]   y_q, y_d;
   logic [4:0]        cnt_q, cnt_d;
   logic              neg_q, neg_d;
   logic              bzero_q, bzero_d;
   logic              ovf_q, ovf_d;

   // Operand conditioning for a new launch
   logic            in_div, sign_a, sign_b, sa, sb;
   logic [XLEN-1:0] abs_a, abs_b;

   always_comb begin
      in_div = op[2];
      sign_a = in_div ? ~op[0] : (op == OP_MULH || op == OP_MULHSU);
      sign_b = in_div ? ~op[0] : (op == OP_MULH);
      sa     = sign_a & a[XLEN-1];
      sb     = sign_b & b[XLEN-1];
      abs_a  = sa ? -a : a;
      abs_b  = sb ? -b : b;
   end

   // Shared datapath: add for multiply, subtract (with borrow in bit XLEN+1) for divide
   logic            is_div;
   logic [XLEN:0]   lhs;
   logic [XLEN+1:0] rhs, sum;
   logic            fits;

   always_comb begin
      is_div = op_q[2];
      lhs    = is_div ? {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} : {1'b0, acc_q[2*XLEN-1:XLEN]};
      rhs    = is_div ? ~{2'b00, m_q} : {2'b00, m_q};
      sum    = {1'b0, lhs} + rhs + {{(XLEN+1){1'b0}}, is_div};
      fits   = ~sum[XLEN+1];
   end

   // Final result selection
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem, res;

   always_comb begin
      prod = neg_q ? -acc_q : acc_q;
      quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      if (!is_div) begin
         res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end else if (!op_q[1]) begin
         if (bzero_q) res = '1;
         else if (ovf_q) res = {1'b1, {(XLEN-1){1'b0}}};
         else res = quo;
      end else begin
         // Remainder by zero falls out naturally: |a| re-signed by a's sign is a
         res = ovf_q ? '0 : rem;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      acc_d   = acc_q;
      m_d     = m_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      bzero_d = bzero_q;
      ovf_d   = ovf_q;
      if (kill) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_CALC;
                  op_d    = op;
                  cnt_d   = 5'd31;
                  neg_d   = (in_div && op[1]) ? sa : (sa ^ sb);
                  bzero_d = (b == '0);
                  ovf_d   = (op == OP_DIV || op == OP_REM) && (a == {1'b1, {(XLEN-1){1'b0}}})
                            && (b == '1);
                  acc_d   = {{XLEN{1'b0}}, in_div ? abs_a : abs_b};
                  m_d     = in_div ? abs_b : abs_a;
               end
            end
            S_CALC: begin
               if (is_div) begin
                  acc_d = {fits ? sum[XLEN-1:0] : lhs[XLEN-1:0], acc_q[XLEN-2:0], fits};
               end else if (acc_q[0]) begin
                  acc_d = {sum[XLEN:0], acc_q[XLEN-1:1]};
               end else begin
                  acc_d = {1'b0, acc_q[2*XLEN-1:1]};
               end
               cnt_d = cnt_q - 5'd1;
               if (cnt_q == 5'd0) state_d = S_FIX;
            end
            S_FIX: begin
               y_d     = res;
               state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         acc_q   <= '0;
         m_q     <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         bzero_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         m_q     <= m_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         bzero_q <= bzero_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);
   assign y    = y_q;

endmodule
